// File: rtl/counter_game_pkg.sv
// ============================================================================
//  counter_game_pkg
//  Shared types and constants for the four-bit counter game.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package counter_game_pkg;

   localparam int                CNT_W     = 4;
   localparam logic [CNT_W-1:0]  CNT_MAX   = 4'd15;
   localparam logic [CNT_W-1:0]  TALLY_MAX = 4'd15;

   typedef enum logic [1:0] {
      UP1 = 2'b00,
      UP2 = 2'b01,
      DN1 = 2'b10,
      DN2 = 2'b11
   } ctrl_e;

   typedef enum logic [1:0] {
      NONE       = 2'b00,
      LOSER_WON  = 2'b01,
      WINNER_WON = 2'b10
   } who_e;

endpackage

`default_nettype wire

// File: rtl/counter_game_tally_ctr.sv
// ============================================================================
//  tally_ctr
//  Four-bit tally with clear, increment enable and a flag for the increment
//  that lands exactly on the maximum. Holds at the maximum.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tally_ctr
   import counter_game_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_inc,
   output logic o_reached_max
);

   localparam logic [CNT_W-1:0] c_pre_max = TALLY_MAX - CNT_W'(1);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_count <= '0;
      end else if (i_inc && (r_count != TALLY_MAX)) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   // Asserted on the cycle whose increment makes the tally reach the maximum.
   assign o_reached_max = i_inc && !(rst || i_clr) && (r_count == c_pre_max);

endmodule

`default_nettype wire

// File: rtl/counter_game.sv
// ============================================================================
//  counter_game
//  Four-bit up/down counter game with win/loss tallies and auto-restart.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module counter_game
   import counter_game_pkg::*;
(
   input  logic             clock,
   input  logic [1:0]       control,
   input  logic [CNT_W-1:0] initial_value,
   input  logic             INIT,
   output logic [CNT_W-1:0] counter,
   output logic             WINNER,
   output logic             LOSER,
   output logic             GAMEOVER,
   output logic [1:0]       WHO
);

   logic [CNT_W-1:0] r_count;
   logic             r_winner;
   logic             r_loser;
   logic             r_gameover;
   who_e             r_who;

   logic [CNT_W-1:0] w_next;
   logic             w_clr;
   logic             w_hit_max;
   logic             w_hit_zero;
   logic             w_wins_max;
   logic             w_losses_max;

   always_comb begin
      w_next = r_count;
      case (ctrl_e'(control))
         UP1: w_next = r_count + CNT_W'(1);
         UP2: w_next = r_count + CNT_W'(2);
         DN1: w_next = r_count - CNT_W'(1);
         DN2: w_next = r_count - CNT_W'(2);
         default: w_next = r_count;
      endcase
   end

   // Tallies are cleared on the restart edge that follows a game over.
   assign w_clr      = r_gameover;
   assign w_hit_max  = (w_next == CNT_MAX);
   assign w_hit_zero = (w_next == '0);

   tally_ctr u_wins (
      .clk           (clock),
      .rst           (INIT),
      .i_clr         (w_clr),
      .i_inc         (w_hit_max),
      .o_reached_max (w_wins_max)
   );

   tally_ctr u_losses (
      .clk           (clock),
      .rst           (INIT),
      .i_clr         (w_clr),
      .i_inc         (w_hit_zero),
      .o_reached_max (w_losses_max)
   );

   always_ff @(posedge clock) begin
      if (INIT) begin
         r_count    <= initial_value;
         r_winner   <= 1'b0;
         r_loser    <= 1'b0;
         r_gameover <= 1'b0;
         r_who      <= NONE;
      end else if (r_gameover) begin
         r_count    <= initial_value;
         r_winner   <= 1'b0;
         r_loser    <= 1'b0;
         r_gameover <= 1'b0;
      end else begin
         r_count    <= w_next;
         r_winner   <= w_hit_max;
         r_loser    <= w_hit_zero;
         if (w_wins_max) begin
            r_gameover <= 1'b1;
            r_who      <= WINNER_WON;
         end else if (w_losses_max) begin
            r_gameover <= 1'b1;
            r_who      <= LOSER_WON;
         end
      end
   end

   assign counter  = r_count;
   assign WINNER   = r_winner;
   assign LOSER    = r_loser;
   assign GAMEOVER = r_gameover;
   assign WHO      = r_who;

endmodule

`default_nettype wire

// File: tb/tb_counter_game.sv
// ============================================================================
//  tb_counter_game
//  Directed and randomized checks of counter_game against a behavioural model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_counter_game;

   logic       clock = 1'b0;
   logic [1:0] control = 2'b00;
   logic [3:0] initial_value = 4'd0;
   logic       INIT = 1'b1;
   logic [3:0] counter;
   logic       WINNER;
   logic       LOSER;
   logic       GAMEOVER;
   logic [1:0] WHO;

   int checks = 0;
   int errors = 0;

   // Behavioural model of the game, kept as plain integers.
   int m_count = 0;
   int m_wins = 0;
   int m_losses = 0;
   int m_winner = 0;
   int m_loser = 0;
   int m_go = 0;
   int m_who = 0;

   counter_game dut (
      .clock         (clock),
      .control       (control),
      .initial_value (initial_value),
      .INIT          (INIT),
      .counter       (counter),
      .WINNER        (WINNER),
      .LOSER         (LOSER),
      .GAMEOVER      (GAMEOVER),
      .WHO           (WHO)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input int init, input int ctrl, input int iv);
      int delta;
      if (init != 0) begin
         m_count = iv; m_wins = 0; m_losses = 0;
         m_winner = 0; m_loser = 0; m_go = 0; m_who = 0;
      end else if (m_go != 0) begin
         m_count = iv; m_wins = 0; m_losses = 0;
         m_winner = 0; m_loser = 0; m_go = 0;
      end else begin
         delta = (ctrl == 0) ? 1 : (ctrl == 1) ? 2 : (ctrl == 2) ? -1 : -2;
         m_count  = ((m_count + delta) % 16 + 16) % 16;
         m_winner = (m_count == 15) ? 1 : 0;
         m_loser  = (m_count == 0) ? 1 : 0;
         if (m_winner != 0) m_wins++;
         if (m_loser != 0) m_losses++;
         if (m_wins == 15) begin
            m_go = 1; m_who = 2;
         end else if (m_losses == 15) begin
            m_go = 1; m_who = 1;
         end
      end
   endtask

   // Apply inputs, clock one edge, then compare every output with the model.
   task automatic step(input int init, input int ctrl, input int iv);
      INIT = init[0];
      control = ctrl[1:0];
      initial_value = iv[3:0];
      @(posedge clock);
      model_edge(init, ctrl, iv);
      #1;
      chk("counter", counter, m_count[3:0]);
      chk("WINNER", {3'b0, WINNER}, m_winner[3:0]);
      chk("LOSER", {3'b0, LOSER}, m_loser[3:0]);
      chk("GAMEOVER", {3'b0, GAMEOVER}, m_go[3:0]);
      chk("WHO", {2'b0, WHO}, m_who[3:0]);
   endtask

   initial begin
      int n;
      int found;

      // Load 9 for 10 cycles, then count down by one.
      for (int i = 0; i < 10; i++) step(1, 1, 9);
      chk("load_counter", counter, 4'd9);
      for (int i = 0; i < 9; i++) step(0, 2, 9);
      chk("down_reach0", counter, 4'd0);
      chk("down_loser", {3'b0, LOSER}, 4'd1);
      step(0, 2, 9);
      chk("down_wrap15", counter, 4'd15);
      chk("down_winner", {3'b0, WINNER}, 4'd1);
      chk("down_loser_drop", {3'b0, LOSER}, 4'd0);

      // Up-by-2 wrap from 13.
      step(1, 1, 13);
      step(0, 1, 13);
      chk("up2_15", counter, 4'd15);
      step(0, 1, 13);
      chk("up2_1", counter, 4'd1);
      step(0, 1, 13);
      chk("up2_3", counter, 4'd3);

      // Down-by-2 wrap from 1.
      step(1, 3, 1);
      step(0, 3, 1);
      chk("dn2_15", counter, 4'd15);
      step(0, 3, 1);
      chk("dn2_13", counter, 4'd13);

      // Game over by losses.
      step(1, 2, 9);
      found = 0;
      n = 0;
      while (found == 0 && n < 300) begin
         n++;
         step(0, 2, 9);
         if (GAMEOVER === 1'b1) found = 1;
      end
      chk("loss_go_found", found[3:0], 4'd1);
      checks++;
      assert (n == 233)
      else begin
         errors++;
         $error("FAIL loss_go_edge observed %0d expected 233", n);
      end
      chk("loss_go_who", {2'b0, WHO}, 4'd1);
      step(0, 0, 9);
      chk("loss_restart_cnt", counter, 4'd9);
      chk("loss_restart_who", {2'b0, WHO}, 4'd1);

      // Game over by wins.
      step(1, 0, 0);
      found = 0;
      n = 0;
      while (found == 0 && n < 300) begin
         n++;
         step(0, 0, 0);
         if (GAMEOVER === 1'b1) found = 1;
      end
      chk("win_go_found", found[3:0], 4'd1);
      checks++;
      assert (n == 239)
      else begin
         errors++;
         $error("FAIL win_go_edge observed %0d expected 239", n);
      end
      chk("win_go_who", {2'b0, WHO}, 4'd2);
      step(0, 3, 0);

      // Mid-game reset after five losses.
      n = 0;
      while (m_losses < 5 && n < 200) begin
         n++;
         step(0, 2, 0);
      end
      chk("midgame_losses", m_losses[3:0], 4'd5);
      step(1, 2, 7);
      chk("midgame_cnt", counter, 4'd7);
      chk("midgame_who", {2'b0, WHO}, 4'd0);

      // Random play with occasional reloads.
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 149) == 0) ? 1 : 0,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
      end
      // Biased random play so tallies reach game over.
      step(1, 0, int'($urandom_range(0, 15)));
      for (int i = 0; i < 2000; i++) begin
         step(0, ($urandom_range(0, 9) < 8) ? 0 : int'($urandom_range(0, 3)),
              int'($urandom_range(0, 15)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
